// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed wait latency
module dmem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q;
  logic [3:0]            wait_cnt_q;
  logic [31:0]           addr_q, wdata_q, resp_rdata_q;
  logic                  write_q, req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]           mem_q [DEPTH];
  logic                  accept, enter_resp, acc_write, acc_err;
  logic [31:0]           acc_addr, acc_wdata, acc_off;
  logic [ADDR_WIDTH-1:0] acc_idx;
  assign accept     = req_valid && req_ready_q;
  assign enter_resp = (accept && LATENCY == 0) || (state_q == WAIT && wait_cnt_q == 4'd1);
  // with zero latency the access happens on the accept edge, so use the live request
  assign acc_addr   = state_q == IDLE ? req_addr : addr_q;
  assign acc_wdata  = state_q == IDLE ? req_wdata : wdata_q;
  assign acc_write  = state_q == IDLE ? req_write : write_q;
  assign acc_off    = acc_addr - BASE_ADDR;
  assign acc_err    = (|acc_addr[1:0]) || (acc_addr < BASE_ADDR) || ((acc_off >> 2) >= 32'(DEPTH));
  assign acc_idx    = acc_off[ADDR_WIDTH+1:2];
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = state_q != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && acc_err;
      if (enter_resp) resp_rdata_q <= (acc_write || acc_err) ? 32'h0 : mem_q[acc_idx];
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      unique case (state_q)
        IDLE: if (accept) begin
          state_q     <= (LATENCY == 0) ? RESP : WAIT;
          wait_cnt_q  <= 4'(LATENCY);
          req_ready_q <= 1'b0;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end
  // reset on the committing edge drops the store
  always_ff @(posedge clock)
    if (!reset && enter_resp && acc_write && !acc_err) mem_q[acc_idx] <= acc_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on three responder configurations
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv [3];
  logic        rw [3];
  logic [31:0] ra [3];
  logic [31:0] rd [3];
  logic        rdy [3];
  logic        vld [3];
  logic        err [3];
  logic        bsy [3];
  logic [31:0] rdat [3];
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clock(clk), .reset(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rd[0]), .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdat[0]),
    .resp_err(err[0]), .busy(bsy[0]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0), .BASE_ADDR(32'h0)) u_l0 (
    .clock(clk), .reset(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rd[1]), .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdat[1]),
    .resp_err(err[1]), .busy(bsy[1]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .BASE_ADDR(32'h100)) u_b1 (
    .clock(clk), .reset(rst), .req_valid(rv[2]), .req_write(rw[2]), .req_addr(ra[2]),
    .req_wdata(rd[2]), .req_ready(rdy[2]), .resp_valid(vld[2]), .resp_rdata(rdat[2]),
    .resp_err(err[2]), .busy(bsy[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one request on instance d; checks exact response cycle, flags and data
  task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    lat = d == 0 ? 2 : d == 1 ? 0 : 1;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(rdy[d]), 32'd1);
    chk({tag, "_idle_vld"}, 32'(vld[d]), 32'd0);
    rv[d] = 1'b1; rw[d] = wr; ra[d] = a; rd[d] = wd;
    @(posedge clk);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      rv[d] = 1'b0;
      chk({tag, "_wait_vld"}, 32'(vld[d]), 32'd0);
      chk({tag, "_wait_busy"}, 32'(bsy[d]), 32'd1);
    end
    @(negedge clk);
    rv[d] = 1'b0;
    chk({tag, "_vld"}, 32'(vld[d]), 32'd1);
    chk({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    chk({tag, "_rdata"}, rdat[d], exp_rd);
    chk({tag, "_resp_rdy"}, 32'(rdy[d]), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdy", 32'(rdy[i]), 32'd1);
      chk("rst_vld", 32'(vld[i]), 32'd0);
      chk("rst_rdata", rdat[i], 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
    end
    // reset in the middle of a store drops it
    xact(0, 1'b1, 32'h10, 32'h0102_0304, 32'h0, 1'b0, "t1_pre");
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10; rd[0] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    chk("t1_busy_wait", 32'(bsy[0]), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t1_rst_rdy", 32'(rdy[0]), 32'd1);
    chk("t1_rst_busy", 32'(bsy[0]), 32'd0);
    chk("t1_rst_vld", 32'(vld[0]), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 32'h0102_0304, 1'b0, "t1_ld");
    // latency 2 store/load
    xact(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, "t2_st");
    xact(0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, "t2_ld");
    @(negedge clk);
    chk("t2_hold", rdat[0], 32'hDEAD_BEEF);
    // zero latency, back-to-back every two cycles
    xact(1, 1'b1, 32'h8, 32'h0000_0007, 32'h0, 1'b0, "t3_st");
    xact(1, 1'b0, 32'h8, 32'h0, 32'h0000_0007, 1'b0, "t3_ld0");
    xact(1, 1'b0, 32'h8, 32'h0, 32'h0000_0007, 1'b0, "t3_ld1");
    xact(1, 1'b1, 32'h3FC, 32'h5555_AAAA, 32'h0, 1'b0, "t3_st2");
    xact(1, 1'b0, 32'h3FC, 32'h0, 32'h5555_AAAA, 1'b0, "t3_ld2");
    // error cases
    xact(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b0, "t4_pre");
    xact(0, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, "t4_mis");
    xact(0, 1'b1, 32'h1000, 32'h0000_0BAD, 32'h0, 1'b1, "t4_oor");
    xact(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, "t4_w0");
    @(negedge clk);
    chk("t4_err_clr", 32'(err[0]), 32'd0);
    // request held with changing address while busy
    xact(0, 1'b1, 32'h80, 32'h1234_5678, 32'h0, 1'b0, "t5_pre");
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h40;
    @(posedge clk);
    @(negedge clk);
    ra[0] = 32'h80;
    chk("t5_w1_vld", 32'(vld[0]), 32'd0);
    chk("t5_w1_rdy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    ra[0] = 32'h84;
    chk("t5_w2_vld", 32'(vld[0]), 32'd0);
    @(negedge clk);
    ra[0] = 32'h80;
    chk("t5_vld", 32'(vld[0]), 32'd1);
    chk("t5_rdata", rdat[0], 32'hDEAD_BEEF);
    chk("t5_resp_rdy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("t5_idle_rdy", 32'(rdy[0]), 32'd1);
    chk("t5_idle_vld", 32'(vld[0]), 32'd0);
    chk("t5_hold", rdat[0], 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    chk("t5_2_w1", 32'(vld[0]), 32'd0);
    @(negedge clk);
    chk("t5_2_w2", 32'(vld[0]), 32'd0);
    @(negedge clk);
    chk("t5_2_vld", 32'(vld[0]), 32'd1);
    chk("t5_2_rdata", rdat[0], 32'h1234_5678);
    // boundaries
    xact(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0, "t6_st_last");
    xact(0, 1'b0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, "t6_ld_last");
    xact(0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, "t6_ld_oor");
    xact(2, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b1, "t6_below_base");
    xact(2, 1'b1, 32'h100, 32'h0BAD_CAFE, 32'h0, 1'b0, "t6_b_st0");
    xact(2, 1'b1, 32'h10FC, 32'h7777_8888, 32'h0, 1'b0, "t6_b_stl");
    xact(2, 1'b0, 32'h100, 32'h0, 32'h0BAD_CAFE, 1'b0, "t6_b_ld0");
    xact(2, 1'b0, 32'h10FC, 32'h0, 32'h7777_8888, 1'b0, "t6_b_ldl");
    xact(2, 1'b0, 32'h1100, 32'h0, 32'h0, 1'b1, "t6_b_oor");
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: timeout expired, expected end of directed sequence");
    $fatal(1, "timeout");
  end
endmodule
